// File: rtl/read16_bytes_pkg.sv
// read16_bytes_pkg: shared AES byte I/O constants and the block assembler state encoding.
package read16_bytes_pkg;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = 128;
  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
endpackage

// File: rtl/read16_bytes.sv
// read16_bytes: assembles 16 received bytes into a 128-bit block on the falling clock edge,
// with overrun flagging and an optional inter-byte timeout.
module read16_bytes
  import read16_bytes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteReady,
  input  logic                  BlockTaken,
  output logic [BLOCK_BITS-1:0] Block,
  output logic                  BlockReady,
  output logic [4:0]            ByteCount,
  output logic                  Overrun,
  output logic                  Timeout
);
  localparam logic [4:0]  LAST_CNT = 5'(BLOCK_BYTES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  state_t                state_q, state_d;
  logic [BLOCK_BITS-1:0] block_q, block_d;
  logic                  ready_q, ready_d, ovr_q, ovr_d, to_q, to_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [15:0]           idle_q, idle_d;
  logic                  accept;
  assign accept = ByteReady && (state_q != FULL || BlockTaken);
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    to_d    = 1'b0;
    idle_d  = idle_q;
    if (!En) begin
      state_d = IDLE;
      ready_d = 1'b0;
      cnt_d   = 5'd0;
      ovr_d   = 1'b0;
      idle_d  = 16'd0;
    end else begin
      if (state_q == FULL) begin
        if (BlockTaken) begin
          ready_d = 1'b0;
          cnt_d   = 5'd0;
          state_d = COLLECT;
        end else if (ByteReady) begin
          ovr_d = 1'b1;
        end
      end else begin
        state_d = COLLECT;
      end
      if (accept) begin
        block_d = {block_q[BLOCK_BITS-9:0], ByteIn};
        cnt_d   = (state_q == FULL) ? 5'd1 : cnt_q + 5'd1;
        idle_d  = 16'd0;
        if (state_q != FULL && cnt_q == LAST_CNT) begin
          state_d = FULL;
          ready_d = 1'b1;
        end
      end else if (TIMEOUT_CYCLES != 0 && state_q == COLLECT && cnt_q != 5'd0) begin
        // A strobe on the expiring edge takes the accept branch above, so the byte wins.
        idle_d = (idle_q == TO_LAST) ? 16'd0 : idle_q + 16'd1;
        cnt_d  = (idle_q == TO_LAST) ? 5'd0 : cnt_q;
        to_d   = (idle_q == TO_LAST);
      end
    end
  end
  always_ff @(negedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      block_q <= '0;
      ready_q <= 1'b0;
      cnt_q   <= 5'd0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
      idle_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
    end
  end
  assign Block      = block_q;
  assign BlockReady = ready_q;
  assign ByteCount  = cnt_q;
  assign Overrun    = ovr_q;
  assign Timeout    = to_q;
endmodule

// File: tb/tb_read16_bytes.sv
// tb_read16_bytes: directed scenarios for the 16-byte block assembler (timeout set to 10 cycles).
module tb_read16_bytes;
  logic         Clk = 1'b1;
  logic         Rst = 1'b0;
  logic         En = 1'b0;
  logic [7:0]   ByteIn = 8'h00;
  logic         ByteReady = 1'b0;
  logic         BlockTaken = 1'b0;
  logic [127:0] Block;
  logic         BlockReady;
  logic [4:0]   ByteCount;
  logic         Overrun;
  logic         Timeout;
  int n_cmp = 0;
  int n_bad = 0;

  read16_bytes #(.TIMEOUT_CYCLES(10)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .ByteIn(ByteIn), .ByteReady(ByteReady),
    .BlockTaken(BlockTaken), .Block(Block), .BlockReady(BlockReady),
    .ByteCount(ByteCount), .Overrun(Overrun), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  // Drive one active (falling) edge, then leave outputs 2 time units to settle.
  task automatic cyc(input logic rdy, input logic [7:0] b, input logic tk);
    ByteReady = rdy;
    ByteIn = b;
    BlockTaken = tk;
    @(negedge Clk);
    #2;
    ByteReady = 1'b0;
    BlockTaken = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (Block !== 128'h0) begin n_bad++; $display("FAIL rst_block got %h want 0", Block); end
    n_cmp++; if (BlockReady !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", BlockReady); end
    n_cmp++; if (ByteCount !== 5'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", ByteCount); end
    n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %b want 0", Overrun); end
    n_cmp++; if (Timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout got %b want 0", Timeout); end
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    En = 1'b1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      n_cmp++; if (ByteCount !== 5'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d] got %0d want %0d", i, ByteCount, i + 1); end
      n_cmp++; if (BlockReady !== (i == 15)) begin n_bad++; $display("FAIL fill_ready[%0d] got %b want %b", i, BlockReady, i == 15); end
      if (i < 15) repeat (3) cyc(1'b0, 8'h00, 1'b0);
    end
    n_cmp++; if (Block !== 128'h000102030405060708090A0B0C0D0E0F) begin n_bad++; $display("FAIL fill_block got %h want 000102030405060708090a0b0c0d0e0f", Block); end
  endtask

  task automatic test_overrun;
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    n_cmp++; if (Block !== 128'h000102030405060708090A0B0C0D0E0F) begin n_bad++; $display("FAIL ovr_block got %h want 000102030405060708090a0b0c0d0e0f", Block); end
    n_cmp++; if (Overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", Overrun); end
    n_cmp++; if (ByteCount !== 5'd16) begin n_bad++; $display("FAIL ovr_count got %0d want 16", ByteCount); end
    n_cmp++; if (BlockReady !== 1'b1) begin n_bad++; $display("FAIL ovr_ready got %b want 1", BlockReady); end
    cyc(1'b0, 8'h00, 1'b1);
    n_cmp++; if (ByteCount !== 5'd0) begin n_bad++; $display("FAIL take_count got %0d want 0", ByteCount); end
    n_cmp++; if (BlockReady !== 1'b0) begin n_bad++; $display("FAIL take_ready got %b want 0", BlockReady); end
    n_cmp++; if (Overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", Overrun); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    n_cmp++; if (BlockReady !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_full got %b want 1", BlockReady); end
    cyc(1'b1, 8'h5A, 1'b1);
    n_cmp++; if (BlockReady !== 1'b0) begin n_bad++; $display("FAIL b2b_ready got %b want 0", BlockReady); end
    n_cmp++; if (ByteCount !== 5'd1) begin n_bad++; $display("FAIL b2b_count got %0d want 1", ByteCount); end
    n_cmp++; if (Block !== 128'h1112131415161718191A1B1C1D1E1F5A) begin n_bad++; $display("FAIL b2b_block got %h want 1112131415161718191a1b1c1d1e1f5a", Block); end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h61 + 8'(i), 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      n_cmp++; if (Timeout !== 1'b0 || ByteCount !== 5'd5) begin n_bad++; $display("FAIL to_early[%0d] got to=%b cnt=%0d want to=0 cnt=5", i, Timeout, ByteCount); end
    end
    cyc(1'b0, 8'h00, 1'b0);
    n_cmp++; if (Timeout !== 1'b1) begin n_bad++; $display("FAIL to_pulse got %b want 1", Timeout); end
    n_cmp++; if (ByteCount !== 5'd0) begin n_bad++; $display("FAIL to_count got %0d want 0", ByteCount); end
    n_cmp++; if (Block !== 128'h15161718191A1B1C1D1E1F5A61626364) begin n_bad++; $display("FAIL to_block got %h want 15161718191a1b1c1d1e1f5a61626364", Block); end
    cyc(1'b0, 8'h00, 1'b0);
    n_cmp++; if (Timeout !== 1'b0) begin n_bad++; $display("FAIL to_width got %b want 0", Timeout); end
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0);
    repeat (9) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h75, 1'b0);
    n_cmp++; if (Timeout !== 1'b0) begin n_bad++; $display("FAIL to_win got %b want 0", Timeout); end
    n_cmp++; if (ByteCount !== 5'd6) begin n_bad++; $display("FAIL to_win_count got %0d want 6", ByteCount); end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 8'h76, 1'b0);
    n_cmp++; if (ByteCount !== 5'd7) begin n_bad++; $display("FAIL ar_pre_count got %0d want 7", ByteCount); end
    #3 Rst = 1'b0;
    #1;
    n_cmp++; if (Block !== 128'h0) begin n_bad++; $display("FAIL ar_block got %h want 0", Block); end
    n_cmp++; if (ByteCount !== 5'd0) begin n_bad++; $display("FAIL ar_count got %0d want 0", ByteCount); end
    #2 Rst = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
    n_cmp++; if (Block !== 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF) begin n_bad++; $display("FAIL ar_block_new got %h want c0c1c2c3c4c5c6c7c8c9cacbcccdcecf", Block); end
    n_cmp++; if (BlockReady !== 1'b1 || ByteCount !== 5'd16) begin n_bad++; $display("FAIL ar_full got rdy=%b cnt=%0d want rdy=1 cnt=16", BlockReady, ByteCount); end
  endtask

  task automatic test_enable;
    cyc(1'b1, 8'hEE, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0);
    n_cmp++; if (Overrun !== 1'b1 || ByteCount !== 5'd9) begin n_bad++; $display("FAIL en_pre got ovr=%b cnt=%0d want ovr=1 cnt=9", Overrun, ByteCount); end
    En = 1'b0;
    cyc(1'b1, 8'h77, 1'b0);
    n_cmp++; if (ByteCount !== 5'd0 || BlockReady !== 1'b0 || Overrun !== 1'b0) begin n_bad++; $display("FAIL en_clear got cnt=%0d rdy=%b ovr=%b want 0 0 0", ByteCount, BlockReady, Overrun); end
    n_cmp++; if (Block !== 128'hC9CACBCCCDCECFD0D1D2D3D4D5D6D7D8) begin n_bad++; $display("FAIL en_hold got %h want c9cacbcccdcecfd0d1d2d3d4d5d6d7d8", Block); end
    En = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'hE0 + 8'(i), 1'b0);
    n_cmp++; if (Block !== 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF) begin n_bad++; $display("FAIL en_block got %h want e0e1e2e3e4e5e6e7e8e9eaebecedeeef", Block); end
    n_cmp++; if (ByteCount !== 5'd16 || BlockReady !== 1'b1) begin n_bad++; $display("FAIL en_full got cnt=%0d rdy=%b want 16 1", ByteCount, BlockReady); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overrun;
    test_back_to_back;
    test_timeout;
    test_async_reset;
    test_enable;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/read16_bytes.md
READ16_BYTES -- requirements
Module: read16_bytes

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 0: inter-byte timeout in Clk cycles; 0 disables the timeout; legal range 0..65535.
REQ-002 Clk  input  1  single block clock; all state updates on the falling edge of Clk.
REQ-003 Rst  input  1  asynchronous, active-low reset.
REQ-004 En  input  1  enable; high = collect blocks, low = abort and idle.
REQ-005 ByteIn  input  8  received byte, valid when ByteReady is high.
REQ-006 ByteReady  input  1  one-cycle strobe from the byte receiver: ByteIn is valid.
REQ-007 BlockTaken  input  1  consumer acknowledge that Block has been read.
REQ-008 Block  output  128  assembled block; first received byte in [127:120], 16th byte in [7:0].
REQ-009 BlockReady  output  1  level; high while Block holds 16 unconsumed bytes.
REQ-010 ByteCount  output  5  bytes accepted into the current block, 0..16.
REQ-011 Overrun  output  1  sticky; a byte arrived while BlockReady was high.
REQ-012 Timeout  output  1  one-cycle pulse; a partial block was discarded by the inter-byte timeout.

Function
REQ-013 The block SHALL implement states IDLE, COLLECT and FULL.
REQ-014 IDLE SHALL move to COLLECT on the first edge with En=1; a ByteReady on that same edge SHALL be accepted as byte 1.
REQ-015 In COLLECT, each ByteReady SHALL shift ByteIn into Block ({Block[119:0], ByteIn}) and increment ByteCount on the same edge.
REQ-016 On the edge that accepts byte 16, ByteCount SHALL become 16, BlockReady SHALL become 1 and the state SHALL become FULL (zero-cycle latency from the 16th strobe).
REQ-017 In FULL, Block and ByteCount SHALL hold, and BlockReady SHALL stay high until BlockTaken is sampled high.
REQ-018 In FULL, when BlockTaken=1 and ByteReady=0: BlockReady=0, ByteCount=0, next state COLLECT.
REQ-019 In FULL, when BlockTaken=1 and ByteReady=1 on the same edge: the byte SHALL be accepted as byte 1 of the next block (ByteCount=1), BlockReady=0, next state COLLECT.
REQ-020 In FULL, when ByteReady=1 and BlockTaken=0: the byte SHALL be dropped and Overrun SHALL be set to 1.
REQ-021 BlockTaken outside FULL SHALL be ignored.
REQ-022 With TIMEOUT_CYCLES>0, a 16-bit idle counter SHALL run in COLLECT while 1<=ByteCount<=15; it SHALL be cleared by every accepted byte.
REQ-023 When the idle counter reaches TIMEOUT_CYCLES: ByteCount=0, Timeout=1 for one cycle, Block unchanged, state remains COLLECT; a ByteReady on that edge SHALL win (byte accepted, no timeout).
REQ-024 The idle counter SHALL NOT run when ByteCount=0 or in FULL.
REQ-025 En=0 from any state SHALL, on the next edge: clear ByteCount, BlockReady, Timeout, Overrun and the idle counter, hold Block, and enter IDLE; ByteReady SHALL be ignored while En=0.
REQ-026 ByteCount SHALL never exceed 16 or wrap.

Reset
REQ-027 Rst=0 SHALL immediately force state IDLE, Block=128'h0, BlockReady=0, ByteCount=0, Overrun=0, Timeout=0 and idle counter=0, independent of Clk.
REQ-028 Deassertion of Rst SHALL take effect at the first falling Clk edge after release; a reset in the middle of a block SHALL discard the partial block.

Structure
REQ-029 The shared AES I/O package SHALL hold the state encoding (IDLE, COLLECT, FULL), BLOCK_BYTES=16 and BLOCK_BITS=128, and the existing 16-byte transmit block SHALL use the same constants.
REQ-030 The design SHALL be a single module; the timeout counter SHALL be inline and SHALL NOT be a separate sub-module.

Verification
REQ-031 Sixteen strobes with bytes 8'h00..8'h0F, gaps of 3 cycles -> Block=128'h000102030405060708090A0B0C0D0E0F, BlockReady rises on the 16th strobe edge, ByteCount=16.
REQ-032 Full block held, then 2 strobes (8'hAA, 8'hBB) before BlockTaken -> Block unchanged, Overrun=1, ByteCount stays 16; after BlockTaken, ByteCount=0.
REQ-033 FULL with BlockTaken and ByteReady (8'h5A) on the same edge -> BlockReady=0, ByteCount=1, Block[7:0]=8'h5A.
REQ-034 TIMEOUT_CYCLES=10, 5 bytes, then 10 idle cycles -> Timeout pulses for exactly 1 cycle and ByteCount=0; a byte on cycle 10 instead -> no Timeout, ByteCount=6.
REQ-035 Rst=0 asserted between Clk edges after 7 bytes -> all outputs cleared immediately; after release, 16 new bytes form a correct block.
REQ-036 En dropped after 9 bytes, then re-raised -> ByteCount=0, BlockReady=0, Overrun=0, and the next block assembles from byte 1.
